// File: rtl/timer_device.sv
// timer_device: programmable 32-bit down-counting timer with CTRL/PRESET/COUNT
// registers and a maskable interrupt line.
//
// Build option: define TIMER_AUTORELOAD_EN to make Mode 01 auto-reload. When it
// is undefined, every Mode value behaves as one-shot. The Mode field is still
// stored and read back either way.
module timer_device (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    localparam logic [1:0] AddrCtrl   = 2'b00;
    localparam logic [1:0] AddrPreset = 2'b01;
    localparam logic [1:0] AddrCount  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e      state_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic        im_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        pending_q;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        reload_mode;

    assign wr_ctrl   = WE && (Addr == AddrCtrl);
    assign wr_preset = WE && (Addr == AddrPreset);

`ifdef TIMER_AUTORELOAD_EN
    // Only Mode 01 reloads; Mode 1x falls back to one-shot.
    assign reload_mode = (mode_q == 2'b01);
`else
    assign reload_mode = 1'b0;
`endif

    // Counter FSM plus software register writes. Later assignments in this
    // block win, which sets the collision priorities: a software pending clear
    // is placed before the FSM so the CNT->INT pending set wins over it, and
    // the CTRL write is placed after the FSM so it wins over INT clearing
    // Enable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            if (wr_ctrl || wr_preset) begin
                pending_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (en_q) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!en_q) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // COUNT of 1 or 0 both terminate the period at zero.
                        count_q   <= 32'd0;
                        pending_q <= 1'b1;
                        state_q   <= StInt;
                    end
                end
                StInt: begin
                    if (reload_mode) begin
                        pending_q <= 1'b0;
                        state_q   <= StLoad;
                    end else begin
                        en_q    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (wr_ctrl) begin
                en_q   <= DIn[0];
                mode_q <= DIn[2:1];
                im_q   <= DIn[3];
            end
            if (wr_preset) begin
                preset_q <= DIn;
            end
        end
    end

    // Combinational read mux; unmapped address reads zero.
    always_comb begin
        DOut = 32'd0;
        unique case (Addr)
            AddrCtrl:   DOut = {28'd0, im_q, mode_q, en_q};
            AddrPreset: DOut = preset_q;
            AddrCount:  DOut = count_q;
            default:    DOut = 32'd0;
        endcase
    end

    // Interrupt is the masked pending flag.
    always_comb begin
        IRQ = im_q & pending_q;
    end

endmodule

// File: tb/tb_timer_device.sv
// Directed testbench for timer_device.
module tb_timer_device;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    timer_device dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        DIn  = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = DOut;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        WE    = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got %h want 0", a, v);
            end
        end
        n_tests++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got %b want 0", IRQ);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        write_reg(2'b01, 32'd5);
        write_reg(2'b00, 32'h9);     // edge t
        tick();                      // t+1: LOAD
        for (int k = 2; k <= 7; k++) begin
            tick();
            read_reg(2'b10, v);
            n_tests++;
            if (v !== 32'(7 - k)) begin
                n_fail++;
                $display("FAIL oneshot_count t+%0d got %0d want %0d", k, v, 7 - k);
            end
            n_tests++;
            if (IRQ !== logic'(k == 7)) begin
                n_fail++;
                $display("FAIL oneshot_irq t+%0d got %b want %b", k, IRQ, k == 7);
            end
        end
        tick();                      // INT clears Enable
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 32'h8) begin
            n_fail++;
            $display("FAIL oneshot_ctrl got %h want 8", v);
        end
        repeat (3) tick();
        read_reg(2'b10, v);
        n_tests++;
        if (IRQ !== 1'b1 || v !== 32'd0) begin
            n_fail++;
            $display("FAIL oneshot_hold irq=%b count=%0d want irq=1 count=0", IRQ, v);
        end
        write_reg(2'b00, 32'h8);
        n_tests++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_ack got %b want 0", IRQ);
        end
    endtask

    task automatic test_masked();
        logic [31:0] v;
        do_reset();
        write_reg(2'b01, 32'd10);
        write_reg(2'b00, 32'h1);     // edge t
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_tests++;
            if (IRQ !== 1'b0) begin
                n_fail++;
                $display("FAIL masked_irq t+%0d got %b want 0", k, IRQ);
            end
            if (k == 12) begin
                read_reg(2'b10, v);
                n_tests++;
                if (v !== 32'd0) begin
                    n_fail++;
                    $display("FAIL masked_count got %0d want 0", v);
                end
            end
        end
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL masked_ctrl got %h want 0", v);
        end
        write_reg(2'b00, 32'h8);
        read_reg(2'b00, v);
        n_tests++;
        if (IRQ !== 1'b0 || v !== 32'h8) begin
            n_fail++;
            $display("FAIL masked_unmask irq=%b ctrl=%h want irq=0 ctrl=8", IRQ, v);
        end
    endtask

    task automatic test_midcount();
        logic [31:0] v;
        do_reset();
        write_reg(2'b01, 32'd100);
        write_reg(2'b00, 32'h9);     // edge t
        repeat (42) tick();          // t+42
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd60) begin
            n_fail++;
            $display("FAIL mid_reach60 got %0d want 60", v);
        end
        write_reg(2'b00, 32'h8);     // FSM still sees Enable=1 this edge
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd59) begin
            n_fail++;
            $display("FAIL mid_stop_edge got %0d want 59", v);
        end
        repeat (4) tick();
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd59) begin
            n_fail++;
            $display("FAIL mid_frozen got %0d want 59", v);
        end
        write_reg(2'b10, 32'hFFFF);
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd59) begin
            n_fail++;
            $display("FAIL mid_count_ro got %0d want 59", v);
        end
        write_reg(2'b00, 32'h9);     // edge w
        tick();                      // w+1: LOAD
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd59) begin
            n_fail++;
            $display("FAIL mid_load_cycle got %0d want 59", v);
        end
        tick();                      // w+2
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd100) begin
            n_fail++;
            $display("FAIL mid_reload got %0d want 100", v);
        end
        tick();
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd99) begin
            n_fail++;
            $display("FAIL mid_resume got %0d want 99", v);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        do_reset();
        write_reg(2'b01, 32'd50);
        write_reg(2'b00, 32'h9);     // edge t
        repeat (12) tick();          // t+12
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd40) begin
            n_fail++;
            $display("FAIL rstmid_pre got %0d want 40", v);
        end
        Reset = 1'b1;
        Addr  = 2'b01;
        DIn   = 32'd7;
        WE    = 1'b1;
        tick();
        Reset = 1'b0;
        WE    = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL rstmid_read addr=%0d got %h want 0", a, v);
            end
        end
        n_tests++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_irq got %b want 0", IRQ);
        end
        repeat (3) tick();
        read_reg(2'b10, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_idle got %0d want 0", v);
        end
    endtask

    task automatic test_mode01();
        logic [31:0] v;
        do_reset();
        write_reg(2'b01, 32'd3);
        write_reg(2'b00, 32'hB);     // edge t
        tick();                      // t+1
`ifdef TIMER_AUTORELOAD_EN
        for (int c = 0; c < 15; c++) begin
            int phase;
            logic [31:0] exp_cnt;
            phase = c % 5;
            exp_cnt = (phase <= 3) ? 32'(3 - phase) : 32'd0;
            tick();
            read_reg(2'b10, v);
            n_tests++;
            if (v !== exp_cnt || IRQ !== logic'(phase == 3)) begin
                n_fail++;
                $display("FAIL reload_cycle c=%0d count=%0d irq=%b want count=%0d irq=%b",
                         c, v, IRQ, exp_cnt, phase == 3);
            end
        end
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 32'hB) begin
            n_fail++;
            $display("FAIL reload_ctrl got %h want b", v);
        end
`else
        for (int k = 2; k <= 5; k++) begin
            tick();
            read_reg(2'b10, v);
            n_tests++;
            if (v !== 32'(5 - k) || IRQ !== logic'(k == 5)) begin
                n_fail++;
                $display("FAIL mode01_cycle t+%0d count=%0d irq=%b want count=%0d irq=%b",
                         k, v, IRQ, 5 - k, k == 5);
            end
        end
        repeat (4) tick();
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 32'hA || IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL mode01_oneshot ctrl=%h irq=%b want ctrl=a irq=1", v, IRQ);
        end
`endif
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        // N=0 boundary, then a CTRL write landing on the INT edge.
        do_reset();
        write_reg(2'b01, 32'd0);
        write_reg(2'b00, 32'h9);     // edge t
        repeat (3) tick();           // t+3
        n_tests++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_preset_irq got %b want 1", IRQ);
        end
        write_reg(2'b00, 32'h9);     // edge t+4, INT edge
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 32'h9 || IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_vs_int ctrl=%h irq=%b want ctrl=9 irq=0", v, IRQ);
        end
        repeat (2) tick();           // t+6
        n_tests++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_vs_int_restart got %b want 0", IRQ);
        end
        tick();                      // t+7
        n_tests++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL ctrl_vs_int_refire got %b want 1", IRQ);
        end
        // PRESET write on the CNT->INT edge: pending set wins.
        do_reset();
        write_reg(2'b01, 32'd2);
        write_reg(2'b00, 32'h9);     // edge t
        repeat (3) tick();           // t+3, COUNT=1
        write_reg(2'b01, 32'd7);     // edge t+4
        read_reg(2'b01, v);
        n_tests++;
        if (v !== 32'd7 || IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL preset_vs_set preset=%0d irq=%b want preset=7 irq=1", v, IRQ);
        end
    endtask

    initial begin
        Reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'b00;
        DIn   = 32'd0;
        tick();
        tick();
        test_reset();
        test_oneshot();
        test_masked();
        test_midcount();
        test_reset_midcount();
        test_mode01();
        test_collisions();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_device.md
# timer_device

Programmable 32-bit down-counting timer on the processor bridge, addressed at 0x7F00–0x7F0B (instance 0) and 0x7F10–0x7F1B (instance 1). It takes the bridge write strobe, word address and store data from the memory stage. It returns read data on PrRD and drives one HWInt line per instance into CP0. Each instance holds three word registers: CTRL, PRESET and COUNT.

## Interface
Parameters: none.
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Addr  input  2  register select = bus address [3:2]; 2'b00 CTRL, 2'b01 PRESET, 2'b10 COUNT, 2'b11 unmapped
- WE  input  1  write strobe for this instance (bridge-decoded PrWE)
- DIn  input  32  write data
- DOut  output  32  combinational read data for Addr
- IRQ  output  1  interrupt request to CP0 HWInt

## Operation
- CTRL fields: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled). Bits [31:4] are not stored and read 0.
- PRESET: 32-bit reload value, read/write.
- COUNT: read-only. Writes with Addr=2'b10 are ignored. Writes with Addr=2'b11 are ignored, and reads there return 0.
- A write to CTRL or PRESET clears the pending flag.
- IRQ = IM & pending.
- State machine, state register reset to IDLE:
  - IDLE: if Enable=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If Enable=0, go to IDLE; COUNT holds.
    - Else if COUNT>1, COUNT <= COUNT-1.
    - Else if COUNT==1, COUNT <= 0, pending <= 1, go to INT.
    - Else (COUNT==0), pending <= 1, go to INT.
  - INT, Mode 00: Enable <= 0; go to IDLE. pending stays set until software writes CTRL or PRESET.
  - INT, Mode 01: pending <= 0; go to LOAD. This gives a one-cycle IRQ pulse per period.
- A PRESET write mid-count does not touch COUNT; the new value takes effect at the next LOAD.
- Clearing Enable mid-count stops the counter on the following cycle with COUNT frozen. Setting Enable again restarts through LOAD, so COUNT is reloaded rather than resumed.
- If a CTRL write lands in the same cycle that INT clears Enable, the software write wins.
- If a CTRL/PRESET write coincides with the CNT→INT pending set, the set wins.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, pending=0, state IDLE, IRQ=0, DOut=0 for every Addr.
- Register writes commit at the rising edge where WE=1. DOut reflects the new value in the following cycle.
- Enable written at edge t:
  - LOAD at t+1.
  - COUNT=PRESET=N at t+2.
  - COUNT=0 and IRQ=1 (if IM=1) at edge t+2+N for N≥1.
  - For N=0, IRQ=1 at t+3.
- Auto-reload with PRESET=N: IRQ pulses 1 cycle high every N+2 cycles.
- Reset asserted mid-count returns every register to its reset value at that edge, regardless of WE.

## Configuration
- TIMER_AUTORELOAD_EN defined: Mode 01 behaves as auto-reload, described above.
- Not defined: every Mode value behaves as one-shot (INT always clears Enable and goes to IDLE).
  - The Mode field is still stored and read back as written.
  - The LOAD return from INT is removed.

## Test plan
- Reset, then read Addr 0/1/2/3 → DOut = 0 for all. IRQ=0.
- Write PRESET=5, then CTRL=0x9 (Enable, one-shot, IM) at edge t:
  - COUNT reads 5 at t+2, 4 at t+3, …, 0 at t+7.
  - IRQ rises at t+7 and stays high.
  - CTRL then reads 0x8.
  - A later write CTRL=0x8 drops IRQ the next cycle.
- With TIMER_AUTORELOAD_EN: PRESET=3, CTRL=0xB → IRQ high for exactly 1 cycle every 5 cycles for ≥3 periods. COUNT sequence 3,2,1,0,(LOAD) repeating.
- PRESET=10, CTRL=0x1 (IM=0): count to 0 → IRQ stays 0 while pending is set. Writing CTRL=0x8 afterwards keeps IRQ=0, because the CTRL write clears pending.
- Mid-count: PRESET=100 running, at COUNT=60:
  - Write CTRL=0x8 → COUNT freezes at ≤60 and state goes to IDLE.
  - Write to Addr=2'b10 with 0xFFFF → COUNT unchanged.
  - Write CTRL=0x9 → COUNT reloads to 100.
- Reset pulse while COUNT=40 and WE=1 writing PRESET=7 → all reads 0 after the edge, IRQ=0.
